mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive LSB grants while ic_req is high before IC is forced ahead.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rdy  input  1  global enable; low freezes all state and outputs.
REQ-005 jp_wrong  input  1  branch-mispredict flush pulse.
REQ-006 ic_req  input  1  ICache fetch request, held high until ic_ack.
REQ-007 ic_addr  input  32  fetch address, word read.
REQ-008 ic_ack  output  1  one-cycle fetch completion pulse.
REQ-009 ic_data  output  32  fetched word, valid with ic_ack.
REQ-010 lsb_req  input  1  LSB request, held high until lsb_ack.
REQ-011 lsb_we  input  1  1 = store, 0 = load.
REQ-012 lsb_addr  input  32  LSB byte address.
REQ-013 lsb_wdata  input  32  store data, right-aligned.
REQ-014 lsb_size  input  2  00 byte, 01 half, 10 word.
REQ-015 lsb_ack  output  1  one-cycle LSB completion pulse.
REQ-016 lsb_data  output  32  raw load data, no extension, valid with lsb_ack.
REQ-017 io_buffer_full  input  1  UART buffer full.
REQ-018 mc_req  output  1  request to byte-serial memory engine, held until mc_done.
REQ-019 mc_addr, mc_wdata  output  32 each  latched request address and data.
REQ-020 mc_size  output  2  latched size; mc_we output 1 latched write flag.
REQ-021 mc_done  input  1  engine completion pulse; mc_rdata input 32 valid with it.

Function
REQ-022 States: IDLE, BUSY, DRAIN; owner register ∈ {IC, LSB}.
REQ-023 IDLE: grant when a grantable request exists and jp_wrong is low; mc_* are registered and mc_req rises the next cycle with state BUSY.
REQ-024 Priority: LSB over IC, except that IC wins if ic_req is high and lsb_streak == STARVE_LIMIT.
REQ-025 lsb_streak: +1 on each LSB grant while ic_req is high, saturating at STARVE_LIMIT; cleared on IC grant or when ic_req is low.
REQ-026 An LSB request with lsb_addr[17:16] == 2'b11 is not grantable while io_buffer_full is high; IC may be granted in its place.
REQ-027 BUSY: mc_* are held stable; on mc_done, register mc_rdata to the owner's data output, pulse the owner's ack the following cycle, and return to IDLE.
REQ-028 Minimum of one IDLE cycle between transactions; no grant occurs in the cycle an ack is asserted.
REQ-029 jp_wrong in BUSY with owner IC or owner LSB load: move to DRAIN; mc_req stays high until mc_done; the result is discarded with no ack; then return to IDLE.
REQ-030 jp_wrong in BUSY with owner LSB store: no effect; the store completes and is acked.
REQ-031 jp_wrong coincident with mc_done of a killed owner: no ack; go directly to IDLE.
REQ-032 jp_wrong in IDLE: no grant that cycle; lsb_streak is unchanged.
REQ-033 ic_ack and lsb_ack are never high in the same cycle; at most one transaction is outstanding.

Reset
REQ-034 On rst, at any state: state = IDLE, owner = IC, lsb_streak = 0; all outputs 0, including mc_req dropping immediately (a transaction in flight is abandoned).
REQ-035 With rdy low, no state changes, acks are not generated, and outputs hold; rst takes precedence over rdy.

Verification
REQ-036 Idle IC fetch: ic_req, ic_addr = 0x100 -> mc_req next cycle with mc_addr 0x100, mc_we 0; mc_done with rdata 0xDEADBEEF -> ic_ack one cycle later, ic_data 0xDEADBEEF.
REQ-037 Contention and starvation: ic_req and lsb_req held continuously, STARVE_LIMIT = 4 -> grant sequence is LSB x4, then IC, then LSB.
REQ-038 IO backpressure: lsb store to 0x30000 with io_buffer_full = 1 and ic_req high -> IC granted and store not granted; io_buffer_full falls -> store granted after IC ack.
REQ-039 Flush a load: jp_wrong during a BUSY LSB load -> DRAIN, mc_req held until mc_done, no lsb_ack; a flush during a BUSY store -> lsb_ack still issued.
REQ-040 Reset in BUSY: rst asserted mid-transaction -> mc_req = 0, no acks, state IDLE on the next cycle; a fresh ic_req is then served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory engine between the ICache fetch
// port and the load/store buffer (LSB).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global enable; low freezes every register
//   jp_wrong              branch-mispredict flush pulse
//   ic_req/ic_addr        fetch request (word read), held until ic_ack
//   ic_ack/ic_data        one-cycle fetch completion and fetched word
//   lsb_req/lsb_we/lsb_addr/lsb_wdata/lsb_size
//                         load/store request, held until lsb_ack
//   lsb_ack/lsb_data      one-cycle LSB completion and raw load data
//   io_buffer_full        UART buffer full; blocks LSB accesses to the IO window
//   mc_req/mc_addr/mc_wdata/mc_size/mc_we
//                         latched request to the memory engine
//   mc_done/mc_rdata      engine completion pulse and read data
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_ack,
  output logic [31:0] ic_data,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic [1:0]  lsb_size,
  output logic        lsb_ack,
  output logic [31:0] lsb_data,
  input  logic        io_buffer_full,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [1:0]  mc_size,
  output logic        mc_we,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic OWN_IC  = 1'b0;
  localparam logic OWN_LSB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            mc_req_q, mc_req_d;
  logic [31:0]     mc_addr_q, mc_addr_d;
  logic [31:0]     mc_wdata_q, mc_wdata_d;
  logic [1:0]      mc_size_q, mc_size_d;
  logic            mc_we_q, mc_we_d;
  logic            ic_ack_q, ic_ack_d;
  logic [31:0]     ic_data_q, ic_data_d;
  logic            lsb_ack_q, lsb_ack_d;
  logic [31:0]     lsb_data_q, lsb_data_d;

  // Request qualification: IO-window accesses wait while the UART is full.
  logic lsb_ok;
  logic streak_full;
  logic ic_forced;
  logic ack_pending;
  logic kill;

  assign lsb_ok      = lsb_req && !((lsb_addr[17:16] == 2'b11) && io_buffer_full);
  assign streak_full = (streak_q == SW'(STARVE_LIMIT));
  assign ic_forced   = ic_req && streak_full;
  // Requesters still hold req during their ack cycle, so never grant then.
  assign ack_pending = ic_ack_q || lsb_ack_q;
  // Fetches and loads are speculative and die on a flush; stores are not.
  assign kill        = jp_wrong && ((owner_q == OWN_IC) || !mc_we_q);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    mc_req_d   = mc_req_q;
    mc_addr_d  = mc_addr_q;
    mc_wdata_d = mc_wdata_q;
    mc_size_d  = mc_size_q;
    mc_we_d    = mc_we_q;
    ic_ack_d   = 1'b0;
    ic_data_d  = ic_data_q;
    lsb_ack_d  = 1'b0;
    lsb_data_d = lsb_data_q;

    // Streak only counts while IC is actually waiting; a flush in IDLE freezes it.
    if (!ic_req && !((state_q == S_IDLE) && jp_wrong)) begin
      streak_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (!jp_wrong && !ack_pending) begin
          if (ic_forced || (ic_req && !lsb_ok)) begin
            owner_d    = OWN_IC;
            mc_req_d   = 1'b1;
            mc_addr_d  = ic_addr;
            mc_wdata_d = 32'h0;
            mc_size_d  = 2'b10;
            mc_we_d    = 1'b0;
            streak_d   = '0;
            state_d    = S_BUSY;
          end else if (lsb_ok) begin
            owner_d    = OWN_LSB;
            mc_req_d   = 1'b1;
            mc_addr_d  = lsb_addr;
            mc_wdata_d = lsb_wdata;
            mc_size_d  = lsb_size;
            mc_we_d    = lsb_we;
            if (ic_req && !streak_full) begin
              streak_d = streak_q + SW'(1);
            end
            state_d    = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (mc_done) begin
          mc_req_d = 1'b0;
          state_d  = S_IDLE;
          if (!kill) begin
            if (owner_q == OWN_IC) begin
              ic_ack_d  = 1'b1;
              ic_data_d = mc_rdata;
            end else begin
              lsb_ack_d  = 1'b1;
              lsb_data_d = mc_rdata;
            end
          end
        end else if (kill) begin
          state_d = S_DRAIN;
        end
      end

      // Engine cannot be aborted: wait it out and drop the result.
      S_DRAIN: begin
        if (mc_done) begin
          mc_req_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        mc_req_d = 1'b0;
      end
    endcase
  end

  // State register; rst overrides the rdy freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IC;
      streak_q   <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= 32'h0;
      mc_wdata_q <= 32'h0;
      mc_size_q  <= 2'b00;
      mc_we_q    <= 1'b0;
      ic_ack_q   <= 1'b0;
      ic_data_q  <= 32'h0;
      lsb_ack_q  <= 1'b0;
      lsb_data_q <= 32'h0;
    end else if (rdy) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      mc_req_q   <= mc_req_d;
      mc_addr_q  <= mc_addr_d;
      mc_wdata_q <= mc_wdata_d;
      mc_size_q  <= mc_size_d;
      mc_we_q    <= mc_we_d;
      ic_ack_q   <= ic_ack_d;
      ic_data_q  <= ic_data_d;
      lsb_ack_q  <= lsb_ack_d;
      lsb_data_q <= lsb_data_d;
    end
  end

  assign ic_ack   = ic_ack_q;
  assign ic_data  = ic_data_q;
  assign lsb_ack  = lsb_ack_q;
  assign lsb_data = lsb_data_q;
  assign mc_req   = mc_req_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;
  assign mc_size  = mc_size_q;
  assign mc_we    = mc_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: requester agents, a fixed-latency memory engine
// model, per-port scoreboards for returned data and a log of engine grants.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jp_wrong;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ack;
  logic [31:0] ic_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [1:0]  lsb_size;
  logic        lsb_ack;
  logic [31:0] lsb_data;
  logic        io_buffer_full;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [1:0]  mc_size;
  logic        mc_we;
  logic        mc_done;
  logic [31:0] mc_rdata;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_size(lsb_size), .lsb_ack(lsb_ack), .lsb_data(lsb_data),
    .io_buffer_full(io_buffer_full),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_size(mc_size),
    .mc_we(mc_we), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp;
  } txn_t;

  typedef struct packed {
    logic is_lsb;
    txn_t t;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } grant_t;

  txn_t        ic_pend[$];
  txn_t        lsb_pend[$];
  logic [31:0] ic_sb[$];
  logic [31:0] lsb_sb[$];
  grant_t      glog[$];

  int n_vec;
  int n_err;
  int ic_ack_cnt;
  int lsb_ack_cnt;
  bit ic_drop;
  bit lsb_drop;

  // Engine memory image: fixed word at 0x100, otherwise address-derived.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // One cycle: drive agents 2 time units after the edge.
  task automatic tick();
    txn_t t;
    @(posedge clk);
    #2;
    if (ic_drop) begin ic_req = 1'b0; ic_drop = 1'b0; end
    if (lsb_drop) begin lsb_req = 1'b0; lsb_drop = 1'b0; end
    if (!ic_req && ic_pend.size() > 0) begin
      t = ic_pend.pop_front();
      ic_addr = t.addr;
      ic_req  = 1'b1;
      ic_sb.push_back(t.exp);
    end
    if (!lsb_req && lsb_pend.size() > 0) begin
      t = lsb_pend.pop_front();
      lsb_we    = t.we;
      lsb_addr  = t.addr;
      lsb_wdata = t.wdata;
      lsb_size  = t.size;
      lsb_req   = 1'b1;
      lsb_sb.push_back(t.exp);
    end
    if (ic_ack) ic_drop = 1'b1;
    if (lsb_ack) lsb_drop = 1'b1;
  endtask

  task automatic kill_ic();
    ic_req = 1'b0;
    ic_drop = 1'b0;
    if (ic_sb.size() > 0) void'(ic_sb.pop_back());
  endtask

  task automatic kill_lsb();
    lsb_req = 1'b0;
    lsb_drop = 1'b0;
    if (lsb_sb.size() > 0) void'(lsb_sb.pop_back());
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (!(ic_pend.size() == 0 && lsb_pend.size() == 0 && !ic_req && !lsb_req &&
             !mc_req && ic_sb.size() == 0 && lsb_sb.size() == 0) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) timeout(name);
    tick();
  endtask

  task automatic wait_mc_req(input int budget, input string name);
    int k;
    k = 0;
    while (!mc_req && k < budget) begin
      tick();
      k++;
    end
    if (!mc_req) timeout(name);
  endtask

  task automatic wait_mc_done(input int budget, input string name);
    int k;
    k = 0;
    while (!mc_done && k < budget) begin
      tick();
      k++;
    end
    if (!mc_done) timeout(name);
  endtask

  // Memory engine: done pulse three cycles after mc_req is first seen.
  initial begin
    bit eng_busy;
    int eng_cnt;
    eng_busy = 1'b0;
    eng_cnt  = 0;
    mc_done  = 1'b0;
    mc_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mc_done = 1'b0;
      if (rst || !mc_req) begin
        eng_busy = 1'b0;
      end else if (!eng_busy) begin
        eng_busy = 1'b1;
        eng_cnt  = 2;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          mc_done  = 1'b1;
          mc_rdata = mc_we ? 32'h0 : mem_fn(mc_addr);
        end
      end
    end
  end

  // Output monitor: scoreboard pops on acks, grant log, request stability.
  initial begin
    logic   prev_req;
    grant_t last;
    grant_t cur;
    prev_req = 1'b0;
    last     = '0;
    forever begin
      @(negedge clk);
      cur = '{mc_we, mc_addr, mc_wdata, mc_size};
      if (ic_ack || lsb_ack) check("ack_exclusive", 32'(ic_ack && lsb_ack), 32'd0);
      if (ic_ack) begin
        ic_ack_cnt++;
        if (ic_sb.size() == 0) timeout("ic_ack_unexpected");
        else check("ic_data", ic_data, ic_sb.pop_front());
      end
      if (lsb_ack) begin
        lsb_ack_cnt++;
        if (lsb_sb.size() == 0) timeout("lsb_ack_unexpected");
        else check("lsb_data", lsb_data, lsb_sb.pop_front());
      end
      if (mc_req && !prev_req) glog.push_back(cur);
      else if (mc_req && prev_req && cur != last) begin
        n_vec++;
        n_err++;
        $display("FAIL mc_stable: got %h expected %h", cur, last);
      end
      last     = cur;
      prev_req = mc_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vt[7];
  logic [31:0] exp_order[12];

  initial begin
    int base;
    n_vec = 0; n_err = 0; ic_ack_cnt = 0; lsb_ack_cnt = 0;
    ic_drop = 1'b0; lsb_drop = 1'b0;
    rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = 32'h0;
    lsb_req = 1'b0; lsb_we = 1'b0; lsb_addr = 32'h0; lsb_wdata = 32'h0; lsb_size = 2'b00;

    vt[0] = '{1'b0, '{1'b0, 32'h0000_0100, 32'h0,        2'b10, 32'hDEADBEEF}};
    vt[1] = '{1'b0, '{1'b0, 32'h0000_1234, 32'h0,        2'b10, 32'h1234EDCB}};
    vt[2] = '{1'b1, '{1'b0, 32'h0000_2000, 32'h0,        2'b10, 32'h2000DFFF}};
    vt[3] = '{1'b1, '{1'b0, 32'h0001_0003, 32'h0,        2'b00, 32'h0003FFFC}};
    vt[4] = '{1'b1, '{1'b1, 32'h0000_0040, 32'h0000BEEF, 2'b01, 32'h0}};
    vt[5] = '{1'b1, '{1'b1, 32'h0003_0000, 32'h0000_0041, 2'b00, 32'h0}};
    vt[6] = '{1'b0, '{1'b0, 32'hFFFF_FFFC, 32'h0,        2'b10, 32'hFFFC0003}};

    exp_order = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h1000, 32'h2010,
                  32'h2014, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};

    // Reset values
    repeat (3) tick();
    check("rst_mc_req",   32'(mc_req), 32'd0);
    check("rst_ic_ack",   32'(ic_ack), 32'd0);
    check("rst_lsb_ack",  32'(lsb_ack), 32'd0);
    check("rst_mc_addr",  mc_addr, 32'h0);
    check("rst_ic_data",  ic_data, 32'h0);
    check("rst_lsb_data", lsb_data, 32'h0);
    rst = 1'b0;
    tick();

    // Single transactions from the vector table
    for (int i = 0; i < 7; i++) begin
      glog.delete();
      if (vt[i].is_lsb) lsb_pend.push_back(vt[i].t);
      else ic_pend.push_back(vt[i].t);
      wait_idle(200, $sformatf("v%0d_idle", i));
      check($sformatf("v%0d_grants", i), 32'(glog.size()), 32'd1);
      if (glog.size() > 0) begin
        check($sformatf("v%0d_mc_addr", i),  glog[0].addr, vt[i].t.addr);
        check($sformatf("v%0d_mc_we", i),    32'(glog[0].we), 32'(vt[i].t.we));
        check($sformatf("v%0d_mc_size", i),  32'(glog[0].size), 32'(vt[i].t.size));
        check($sformatf("v%0d_mc_wdata", i), glog[0].wdata, vt[i].t.wdata);
      end
    end

    // Contention and starvation limit
    glog.delete();
    for (int i = 0; i < 6; i++) begin
      ic_pend.push_back('{1'b0, 32'h1000 + 32'(4 * i), 32'h0, 2'b10, mem_fn(32'h1000 + 32'(4 * i))});
      lsb_pend.push_back('{1'b0, 32'h2000 + 32'(4 * i), 32'h0, 2'b10, mem_fn(32'h2000 + 32'(4 * i))});
    end
    wait_idle(2000, "contention_idle");
    check("contention_grants", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < glog.size()) check($sformatf("contention_g%0d", i), glog[i].addr, exp_order[i]);
    end

    // IO backpressure: blocked store yields to IC until the buffer drains
    glog.delete();
    io_buffer_full = 1'b1;
    lsb_pend.push_back('{1'b1, 32'h0003_0000, 32'h55, 2'b00, 32'h0});
    ic_pend.push_back('{1'b0, 32'h400, 32'h0, 2'b10, mem_fn(32'h400)});
    repeat (20) tick();
    check("io_grants_blocked", 32'(glog.size()), 32'd1);
    if (glog.size() > 0) check("io_first_ic", glog[0].addr, 32'h400);
    check("io_no_mc_req", 32'(mc_req), 32'd0);
    io_buffer_full = 1'b0;
    wait_idle(200, "io_idle");
    check("io_grants", 32'(glog.size()), 32'd2);
    if (glog.size() > 1) begin
      check("io_store_addr", glog[1].addr, 32'h0003_0000);
      check("io_store_we", 32'(glog[1].we), 32'd1);
      check("io_store_wdata", glog[1].wdata, 32'h55);
    end

    // Flush during a load: drain without ack
    base = lsb_ack_cnt;
    lsb_pend.push_back('{1'b0, 32'h500, 32'h0, 2'b10, mem_fn(32'h500)});
    wait_mc_req(50, "flush_load_grant");
    jp_wrong = 1'b1;
    kill_lsb();
    tick();
    jp_wrong = 1'b0;
    while (!mc_done && mc_req) tick();
    wait_mc_done(20, "flush_load_done");
    check("drain_req_at_done", 32'(mc_req), 32'd1);
    tick();
    check("drain_req_after", 32'(mc_req), 32'd0);
    repeat (3) tick();
    check("flush_load_no_ack", 32'(lsb_ack_cnt), 32'(base));

    // Flush during a store: store still completes
    base = lsb_ack_cnt;
    lsb_pend.push_back('{1'b1, 32'h600, 32'h1234, 2'b10, 32'h0});
    wait_mc_req(50, "flush_store_grant");
    jp_wrong = 1'b1;
    tick();
    jp_wrong = 1'b0;
    wait_idle(200, "flush_store_idle");
    check("flush_store_ack", 32'(lsb_ack_cnt), 32'(base + 1));

    // Flush coincident with mc_done of an IC fetch
    base = ic_ack_cnt;
    ic_pend.push_back('{1'b0, 32'h700, 32'h0, 2'b10, mem_fn(32'h700)});
    wait_mc_req(50, "coinc_grant");
    wait_mc_done(20, "coinc_done");
    jp_wrong = 1'b1;
    kill_ic();
    tick();
    jp_wrong = 1'b0;
    check("coinc_mc_req", 32'(mc_req), 32'd0);
    repeat (3) tick();
    check("coinc_no_ack", 32'(ic_ack_cnt), 32'(base));
    ic_pend.push_back('{1'b0, 32'h704, 32'h0, 2'b10, mem_fn(32'h704)});
    wait_idle(200, "coinc_next_idle");
    check("coinc_next_ack", 32'(ic_ack_cnt), 32'(base + 1));

    // jp_wrong in IDLE blocks grants
    glog.delete();
    jp_wrong = 1'b1;
    ic_pend.push_back('{1'b0, 32'h800, 32'h0, 2'b10, mem_fn(32'h800)});
    repeat (4) tick();
    check("jp_idle_mc_req", 32'(mc_req), 32'd0);
    check("jp_idle_grants", 32'(glog.size()), 32'd0);
    jp_wrong = 1'b0;
    wait_idle(200, "jp_idle_release");
    check("jp_idle_grants_after", 32'(glog.size()), 32'd1);

    // rdy low freezes the arbiter
    glog.delete();
    rdy = 1'b0;
    ic_pend.push_back('{1'b0, 32'h900, 32'h0, 2'b10, mem_fn(32'h900)});
    repeat (4) tick();
    check("rdy_low_mc_req", 32'(mc_req), 32'd0);
    rdy = 1'b1;
    wait_idle(200, "rdy_release");
    check("rdy_grants", 32'(glog.size()), 32'd1);

    // Reset mid-transaction, then a fresh fetch
    base = ic_ack_cnt;
    ic_pend.push_back('{1'b0, 32'hA00, 32'h0, 2'b10, mem_fn(32'hA00)});
    wait_mc_req(50, "rst_busy_grant");
    tick();
    rst = 1'b1;
    kill_ic();
    tick();
    check("rst_busy_mc_req",  32'(mc_req), 32'd0);
    check("rst_busy_ic_ack",  32'(ic_ack), 32'd0);
    check("rst_busy_lsb_ack", 32'(lsb_ack), 32'd0);
    check("rst_busy_mc_addr", mc_addr, 32'h0);
    check("rst_busy_ic_data", ic_data, 32'h0);
    rst = 1'b0;
    glog.delete();
    ic_pend.push_back('{1'b0, 32'h100, 32'h0, 2'b10, 32'hDEADBEEF});
    wait_idle(200, "rst_busy_fresh");
    check("rst_busy_fresh_grants", 32'(glog.size()), 32'd1);
    if (glog.size() > 0) check("rst_busy_fresh_addr", glog[0].addr, 32'h100);
    check("rst_busy_fresh_ack", 32'(ic_ack_cnt), 32'(base + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
